// File: rtl/banco_nos_ativos_pkg.sv
// Shared definitions for the active-node bank and the active-node manager:
// default sizes, derived widths and the search FSM encoding.
package banco_nos_ativos_pkg;

    localparam int unsigned NUM_NA_PADRAO      = 8;
    localparam int unsigned ADR_WIDTH_PADRAO   = 5;
    localparam int unsigned CUSTO_WIDTH_PADRAO = 8;

    // Width of an entry index and of the active-entry count for the default size.
    localparam int unsigned IDX_WIDTH_PADRAO   = $clog2(NUM_NA_PADRAO);
    localparam int unsigned CNT_WIDTH_PADRAO   = $clog2(NUM_NA_PADRAO + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VARRENDO = 2'd1,
        ST_FIM      = 2'd2
    } estado_busca_t;

endpackage

// File: rtl/banco_nos_ativos_registro_na.sv
// One active-node entry: stores endereco, custo and the ativo flag.
// Deactivation wins over a simultaneous write and leaves the stored data intact.
module registro_na
    import banco_nos_ativos_pkg::*;
#(
    parameter int unsigned ADR_WIDTH   = ADR_WIDTH_PADRAO,
    parameter int unsigned CUSTO_WIDTH = CUSTO_WIDTH_PADRAO
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_habilitar,
    input  logic                   i_escrever,
    input  logic                   i_desativar,
    input  logic [ADR_WIDTH-1:0]   i_endereco,
    input  logic [CUSTO_WIDTH-1:0] i_custo,
    output logic [ADR_WIDTH-1:0]   o_endereco,
    output logic [CUSTO_WIDTH-1:0] o_custo,
    output logic                   o_ativo
);

    logic [ADR_WIDTH-1:0]   r_endereco;
    logic [CUSTO_WIDTH-1:0] r_custo;
    logic                   r_ativo;

    // Entry storage: deactivate has priority over write when both are requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_endereco <= '0;
            r_custo    <= '0;
            r_ativo    <= 1'b0;
        end else if (i_habilitar) begin
            if (i_desativar) begin
                r_ativo <= 1'b0;
            end else if (i_escrever) begin
                r_endereco <= i_endereco;
                r_custo    <= i_custo;
                r_ativo    <= 1'b1;
            end
        end
    end

    assign o_endereco = r_endereco;
    assign o_custo    = r_custo;
    assign o_ativo    = r_ativo;

endmodule

// File: rtl/banco_nos_ativos.sv
// Active-node bank: NUM_NA entries plus a sequential minimum-cost search.
// The scan visits one entry per cycle; any accepted write/deactivate during the
// scan restarts it so the result always reflects a consistent snapshot.
module banco_nos_ativos
    import banco_nos_ativos_pkg::*;
#(
    parameter int unsigned NUM_NA      = NUM_NA_PADRAO,
    parameter int unsigned ADR_WIDTH   = ADR_WIDTH_PADRAO,
    parameter int unsigned CUSTO_WIDTH = CUSTO_WIDTH_PADRAO
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_NA-1:0]             habilitar_in,
    input  logic                          escrever_in,
    input  logic                          desativar_in,
    input  logic [ADR_WIDTH-1:0]          endereco_in,
    input  logic [CUSTO_WIDTH-1:0]        custo_in,
    input  logic                          buscar_in,
    output logic [ADR_WIDTH*NUM_NA-1:0]   na_endereco_out,
    output logic [NUM_NA-1:0]             na_ativo_out,
    output logic [$clog2(NUM_NA+1)-1:0]   num_ativos_out,
    output logic                          cheio_out,
    output logic                          vazio_out,
    output logic                          ocupado_out,
    output logic                          menor_valido_out,
    output logic                          menor_nenhum_out,
    output logic [$clog2(NUM_NA)-1:0]     menor_indice_out,
    output logic [ADR_WIDTH-1:0]          menor_endereco_out,
    output logic [CUSTO_WIDTH-1:0]        menor_custo_out
);

    localparam int unsigned IDX_W = $clog2(NUM_NA);
    localparam int unsigned CNT_W = $clog2(NUM_NA + 1);
    localparam logic [IDX_W-1:0] ULTIMO_IDX = IDX_W'(NUM_NA - 1);

    logic [ADR_WIDTH-1:0]   w_endereco [NUM_NA];
    logic [CUSTO_WIDTH-1:0] w_custo    [NUM_NA];

    for (genvar g = 0; g < NUM_NA; g++) begin : g_entrada
        registro_na #(
            .ADR_WIDTH   (ADR_WIDTH),
            .CUSTO_WIDTH (CUSTO_WIDTH)
        ) u_registro_na (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_habilitar (habilitar_in[g]),
            .i_escrever  (escrever_in),
            .i_desativar (desativar_in),
            .i_endereco  (endereco_in),
            .i_custo     (custo_in),
            .o_endereco  (w_endereco[g]),
            .o_custo     (w_custo[g]),
            .o_ativo     (na_ativo_out[g])
        );
        assign na_endereco_out[ADR_WIDTH*g +: ADR_WIDTH] = w_endereco[g];
    end

    // Active-entry count and full/empty flags, same cycle as the ativo vector.
    logic [CNT_W-1:0] w_contagem;

    always_comb begin
        w_contagem = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            w_contagem = w_contagem + CNT_W'(na_ativo_out[i]);
        end
    end

    assign num_ativos_out = w_contagem;
    assign cheio_out      = (w_contagem == CNT_W'(NUM_NA));
    assign vazio_out      = (w_contagem == '0);

    // A write/deactivate only counts when at least one entry is selected.
    logic w_acesso;
    assign w_acesso = (|habilitar_in) & (escrever_in | desativar_in);

    // Search state and registers.
    estado_busca_t          r_estado, w_estado_prox;
    logic [IDX_W-1:0]       r_idx, w_idx_prox;
    logic                   r_cand_valido, w_cand_valido_prox;
    logic [IDX_W-1:0]       r_cand_idx, w_cand_idx_prox;
    logic [ADR_WIDTH-1:0]   r_cand_end, w_cand_end_prox;
    logic [CUSTO_WIDTH-1:0] r_cand_custo, w_cand_custo_prox;
    logic [IDX_W-1:0]       r_menor_idx, w_menor_idx_prox;
    logic [ADR_WIDTH-1:0]   r_menor_end, w_menor_end_prox;
    logic [CUSTO_WIDTH-1:0] r_menor_custo, w_menor_custo_prox;

    // Entry currently under inspection.
    logic                   w_sel_ativo;
    logic [ADR_WIDTH-1:0]   w_sel_end;
    logic [CUSTO_WIDTH-1:0] w_sel_custo;
    logic                   w_substitui;

    assign w_sel_ativo = na_ativo_out[r_idx];
    assign w_sel_end   = w_endereco[r_idx];
    assign w_sel_custo = w_custo[r_idx];
    // Strict less-than keeps the lowest index on ties.
    assign w_substitui = w_sel_ativo & (~r_cand_valido | (w_sel_custo < r_cand_custo));

    // Search state, scan index, candidate and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado      <= ST_IDLE;
            r_idx         <= '0;
            r_cand_valido <= 1'b0;
            r_cand_idx    <= '0;
            r_cand_end    <= '0;
            r_cand_custo  <= '0;
            r_menor_idx   <= '0;
            r_menor_end   <= '0;
            r_menor_custo <= '0;
        end else begin
            r_estado      <= w_estado_prox;
            r_idx         <= w_idx_prox;
            r_cand_valido <= w_cand_valido_prox;
            r_cand_idx    <= w_cand_idx_prox;
            r_cand_end    <= w_cand_end_prox;
            r_cand_custo  <= w_cand_custo_prox;
            r_menor_idx   <= w_menor_idx_prox;
            r_menor_end   <= w_menor_end_prox;
            r_menor_custo <= w_menor_custo_prox;
        end
    end

    // Next-state logic: start on buscar, scan one entry per cycle, publish on the last one.
    always_comb begin
        w_estado_prox      = r_estado;
        w_idx_prox         = r_idx;
        w_cand_valido_prox = r_cand_valido;
        w_cand_idx_prox    = r_cand_idx;
        w_cand_end_prox    = r_cand_end;
        w_cand_custo_prox  = r_cand_custo;
        w_menor_idx_prox   = r_menor_idx;
        w_menor_end_prox   = r_menor_end;
        w_menor_custo_prox = r_menor_custo;

        unique case (r_estado)
            ST_IDLE: begin
                if (buscar_in) begin
                    w_estado_prox      = ST_VARRENDO;
                    w_idx_prox         = '0;
                    w_cand_valido_prox = 1'b0;
                    w_cand_idx_prox    = '0;
                    w_cand_end_prox    = '0;
                    w_cand_custo_prox  = '0;
                end
            end
            ST_VARRENDO: begin
                if (w_acesso) begin
                    // Table changed under the scan: start over from entry 0.
                    w_idx_prox         = '0;
                    w_cand_valido_prox = 1'b0;
                    w_cand_idx_prox    = '0;
                    w_cand_end_prox    = '0;
                    w_cand_custo_prox  = '0;
                end else begin
                    if (w_substitui) begin
                        w_cand_valido_prox = 1'b1;
                        w_cand_idx_prox    = r_idx;
                        w_cand_end_prox    = w_sel_end;
                        w_cand_custo_prox  = w_sel_custo;
                    end
                    if (r_idx == ULTIMO_IDX) begin
                        w_estado_prox = ST_FIM;
                        if (w_cand_valido_prox) begin
                            w_menor_idx_prox   = w_cand_idx_prox;
                            w_menor_end_prox   = w_cand_end_prox;
                            w_menor_custo_prox = w_cand_custo_prox;
                        end else begin
                            w_menor_idx_prox   = '0;
                            w_menor_end_prox   = '0;
                            w_menor_custo_prox = '0;
                        end
                    end else begin
                        w_idx_prox = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_FIM: begin
                w_estado_prox = ST_IDLE;
            end
            default: begin
                w_estado_prox = ST_IDLE;
            end
        endcase
    end

    assign ocupado_out        = (r_estado != ST_IDLE);
    assign menor_valido_out   = (r_estado == ST_FIM);
    assign menor_nenhum_out   = (r_estado == ST_FIM) & ~r_cand_valido;
    assign menor_indice_out   = r_menor_idx;
    assign menor_endereco_out = r_menor_end;
    assign menor_custo_out    = r_menor_custo;

endmodule

// File: tb/tb_banco_nos_ativos.sv
// Self-checking bench for banco_nos_ativos: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a table model.
module tb_banco_nos_ativos;

    localparam int N  = 8;
    localparam int AW = 5;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      habilitar_in;
    logic              escrever_in;
    logic              desativar_in;
    logic [AW-1:0]     endereco_in;
    logic [CW-1:0]     custo_in;
    logic              buscar_in;
    logic [AW*N-1:0]   na_endereco_out;
    logic [N-1:0]      na_ativo_out;
    logic [3:0]        num_ativos_out;
    logic              cheio_out;
    logic              vazio_out;
    logic              ocupado_out;
    logic              menor_valido_out;
    logic              menor_nenhum_out;
    logic [2:0]        menor_indice_out;
    logic [AW-1:0]     menor_endereco_out;
    logic [CW-1:0]     menor_custo_out;

    always #5 clk = ~clk;

    banco_nos_ativos dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .habilitar_in       (habilitar_in),
        .escrever_in        (escrever_in),
        .desativar_in       (desativar_in),
        .endereco_in        (endereco_in),
        .custo_in           (custo_in),
        .buscar_in          (buscar_in),
        .na_endereco_out    (na_endereco_out),
        .na_ativo_out       (na_ativo_out),
        .num_ativos_out     (num_ativos_out),
        .cheio_out          (cheio_out),
        .vazio_out          (vazio_out),
        .ocupado_out        (ocupado_out),
        .menor_valido_out   (menor_valido_out),
        .menor_nenhum_out   (menor_nenhum_out),
        .menor_indice_out   (menor_indice_out),
        .menor_endereco_out (menor_endereco_out),
        .menor_custo_out    (menor_custo_out)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nome, got, exp, $time);
    endtask

    // Table model: entry contents plus search phase (0 idle, 1 scanning, 2 result).
    logic [AW-1:0] m_end   [N];
    logic [CW-1:0] m_custo [N];
    bit            m_ativo [N];
    int            m_fase;
    int            m_restam;
    logic [2:0]    m_res_idx;
    logic [AW-1:0] m_res_end;
    logic [CW-1:0] m_res_custo;
    bit            m_res_nenhum;

    logic [N-1:0]    e_ativo;
    logic [AW*N-1:0] e_end;
    int              e_cnt;
    int              minc;
    int              melhor;
    bit              acesso;

    // Per-cycle comparison against the model, then model advance on the sampled inputs.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) begin
                    m_end[i] = '0; m_custo[i] = '0; m_ativo[i] = 0;
                end
                m_fase = 0; m_restam = 0;
                m_res_idx = '0; m_res_end = '0; m_res_custo = '0; m_res_nenhum = 0;
            end
            if (m_fase == 2) begin
                minc = 1 << CW;
                melhor = -1;
                for (int i = 0; i < N; i++)
                    if (m_ativo[i] && int'(m_custo[i]) < minc) minc = int'(m_custo[i]);
                for (int i = 0; i < N; i++)
                    if (melhor < 0 && m_ativo[i] && int'(m_custo[i]) == minc) melhor = i;
                if (melhor < 0) begin
                    m_res_nenhum = 1; m_res_idx = '0; m_res_end = '0; m_res_custo = '0;
                end else begin
                    m_res_nenhum = 0;
                    m_res_idx    = 3'(melhor);
                    m_res_end    = m_end[melhor];
                    m_res_custo  = m_custo[melhor];
                end
            end
            e_cnt = 0;
            for (int i = 0; i < N; i++) begin
                e_ativo[i] = m_ativo[i];
                e_end[AW*i +: AW] = m_end[i];
                if (m_ativo[i]) e_cnt++;
            end
            chk("na_ativo_out", 64'(na_ativo_out), 64'(e_ativo));
            chk("na_endereco_out", 64'(na_endereco_out), 64'(e_end));
            chk("num_ativos_out", 64'(num_ativos_out), 64'(e_cnt));
            chk("cheio_out", 64'(cheio_out), 64'(e_cnt == N));
            chk("vazio_out", 64'(vazio_out), 64'(e_cnt == 0));
            chk("ocupado_out", 64'(ocupado_out), 64'(m_fase != 0));
            chk("menor_valido_out", 64'(menor_valido_out), 64'(m_fase == 2));
            chk("menor_nenhum_out", 64'(menor_nenhum_out), 64'(m_fase == 2 && m_res_nenhum));
            chk("menor_indice_out", 64'(menor_indice_out), 64'(m_res_idx));
            chk("menor_endereco_out", 64'(menor_endereco_out), 64'(m_res_end));
            chk("menor_custo_out", 64'(menor_custo_out), 64'(m_res_custo));
            if (rst_n) begin
                acesso = (habilitar_in != '0) && (escrever_in || desativar_in);
                case (m_fase)
                    0: if (buscar_in) begin m_fase = 1; m_restam = N; end
                    1: begin
                        if (acesso) m_restam = N;
                        else if (m_restam == 1) m_fase = 2;
                        else m_restam--;
                    end
                    default: m_fase = 0;
                endcase
                for (int i = 0; i < N; i++) begin
                    if (habilitar_in[i]) begin
                        if (desativar_in) m_ativo[i] = 0;
                        else if (escrever_in) begin
                            m_ativo[i] = 1; m_end[i] = endereco_in; m_custo[i] = custo_in;
                        end
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
    task automatic passo(input logic [N-1:0] hab, input logic esc, input logic des,
                         input logic [AW-1:0] e, input logic [CW-1:0] c, input logic busc);
        habilitar_in = hab; escrever_in = esc; desativar_in = des;
        endereco_in = e; custo_in = c; buscar_in = busc;
        @(posedge clk);
        #1;
    endtask

    task automatic ocioso(input int n);
        repeat (n) passo('0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    int pulsos;
    int wprob;
    logic [N-1:0] hab_r;

    initial begin
        rst_n = 1'b0;
        habilitar_in = '0; escrever_in = 0; desativar_in = 0;
        endereco_in = '0; custo_in = '0; buscar_in = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset vazio", 64'(vazio_out), 64'd1);
        chk("reset cheio", 64'(cheio_out), 64'd0);
        chk("reset num_ativos", 64'(num_ativos_out), 64'd0);
        chk("reset ocupado", 64'(ocupado_out), 64'd0);
        chk("reset menor_valido", 64'(menor_valido_out), 64'd0);
        rst_n = 1'b1;

        // Search over an empty table.
        passo('0, 0, 0, '0, '0, 1);
        ocioso(8);
        chk("vazio busca valido", 64'(menor_valido_out), 64'd1);
        chk("vazio busca nenhum", 64'(menor_nenhum_out), 64'd1);
        chk("vazio busca indice", 64'(menor_indice_out), 64'd0);
        chk("vazio busca endereco", 64'(menor_endereco_out), 64'd0);
        chk("vazio busca custo", 64'(menor_custo_out), 64'd0);
        ocioso(1);

        // Entries 2,5,7 with costs 30,10,10: tie resolves to index 5.
        passo(8'h04, 1, 0, 5'd12, 8'd30, 0);
        passo(8'h20, 1, 0, 5'd21, 8'd10, 0);
        passo(8'h80, 1, 0, 5'd3,  8'd10, 0);
        passo('0, 0, 0, '0, '0, 1);
        ocioso(7);
        chk("busca antes do fim", 64'(menor_valido_out), 64'd0);
        ocioso(1);
        chk("busca valido", 64'(menor_valido_out), 64'd1);
        chk("busca nenhum", 64'(menor_nenhum_out), 64'd0);
        chk("busca indice", 64'(menor_indice_out), 64'd5);
        chk("busca custo", 64'(menor_custo_out), 64'd10);
        chk("busca endereco", 64'(menor_endereco_out), 64'd21);
        chk("busca num_ativos", 64'(num_ativos_out), 64'd3);
        ocioso(1);
        chk("pulso unico", 64'(menor_valido_out), 64'd0);
        chk("indice retido", 64'(menor_indice_out), 64'd5);

        // Write entry 0 in the 4th scan cycle: restart, result 4 cycles late.
        passo('0, 0, 0, '0, '0, 1);
        ocioso(3);
        passo(8'h01, 1, 0, 5'd9, 8'd1, 0);
        ocioso(4);
        chk("reinicio sem resultado", 64'(menor_valido_out), 64'd0);
        chk("reinicio ocupado", 64'(ocupado_out), 64'd1);
        ocioso(3);
        chk("reinicio ainda varrendo", 64'(menor_valido_out), 64'd0);
        ocioso(1);
        chk("reinicio valido", 64'(menor_valido_out), 64'd1);
        chk("reinicio indice", 64'(menor_indice_out), 64'd0);
        chk("reinicio custo", 64'(menor_custo_out), 64'd1);
        chk("reinicio endereco", 64'(menor_endereco_out), 64'd9);
        ocioso(1);

        // Write and deactivate together on entry 2: deactivate only.
        passo(8'h04, 1, 1, 5'd31, 8'd99, 0);
        chk("esc+des ativo2", 64'(na_ativo_out[2]), 64'd0);
        chk("esc+des endereco2", 64'(na_endereco_out[14:10]), 64'd12);
        chk("esc+des outros", 64'(na_ativo_out), 64'hA1);

        // Fill all entries, then drop entry 3.
        passo(8'hFF, 1, 0, 5'd7, 8'd50, 0);
        chk("cheio", 64'(cheio_out), 64'd1);
        chk("cheio num", 64'(num_ativos_out), 64'd8);
        passo(8'h08, 0, 1, '0, '0, 0);
        chk("nao cheio", 64'(cheio_out), 64'd0);
        chk("nao cheio num", 64'(num_ativos_out), 64'd7);

        // Reset in the middle of a scan.
        passo('0, 0, 0, '0, '0, 1);
        ocioso(3);
        rst_n = 1'b0;
        #1;
        chk("reset meio ativo", 64'(na_ativo_out), 64'd0);
        chk("reset meio vazio", 64'(vazio_out), 64'd1);
        chk("reset meio ocupado", 64'(ocupado_out), 64'd0);
        @(posedge clk);
        #1;
        ocioso(1);
        rst_n = 1'b1;
        pulsos = 0;
        for (int k = 0; k < 12; k++) begin
            ocioso(1);
            if (menor_valido_out) pulsos++;
        end
        chk("reset meio sem pulso", 64'(pulsos), 64'd0);
        chk("reset meio vazio depois", 64'(vazio_out), 64'd1);

        // Randomized traffic alternating between quiet and busy write periods.
        for (int it = 0; it < 3000; it++) begin
            wprob = ((it / 250) % 2 == 0) ? 4 : 25;
            case ($urandom_range(0, 9))
                0:       hab_r = '0;
                1, 2, 3: hab_r = N'($urandom);
                default: hab_r = N'(1) << $urandom_range(0, N - 1);
            endcase
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                ocioso(1);
                rst_n = 1'b1;
            end
            passo(hab_r,
                  $urandom_range(0, 99) < wprob,
                  $urandom_range(0, 99) < wprob / 2,
                  AW'($urandom),
                  ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 15)),
                  $urandom_range(0, 99) < 15);
        end
        ocioso(12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/banco_nos_ativos.md
BANCO_NOS_ATIVOS -- requirements
Module: banco_nos_ativos

Interface
REQ-001 The block SHALL have parameter NUM_NA, default 8, giving the number of active-node (NA) entries.
REQ-002 The block SHALL have parameter ADR_WIDTH, default 5, giving the node address width.
REQ-003 The block SHALL have parameter CUSTO_WIDTH, default 8, giving the unsigned path-cost width.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port habilitar_in, input, NUM_NA bits: one-hot entry select from the active-node manager.
REQ-007 The block SHALL have port escrever_in, input, 1 bit: write endereco_in and custo_in into the selected entries.
REQ-008 The block SHALL have port desativar_in, input, 1 bit: clear the active flag of the selected entries.
REQ-009 The block SHALL have ports endereco_in (ADR_WIDTH bits) and custo_in (CUSTO_WIDTH bits), both inputs: write data.
REQ-010 The block SHALL have port buscar_in, input, 1 bit: request a minimum-cost search.
REQ-011 The block SHALL have outputs na_endereco_out (ADR_WIDTH*NUM_NA bits; entry i at bits [ADR_WIDTH*i+ADR_WIDTH-1 : ADR_WIDTH*i]) and na_ativo_out (NUM_NA bits), both registered.
REQ-012 The block SHALL have outputs num_ativos_out ($clog2(NUM_NA+1) bits), cheio_out (1 bit) and vazio_out (1 bit).
REQ-013 The block SHALL have outputs ocupado_out (1 bit), menor_valido_out (1 bit), menor_nenhum_out (1 bit), menor_indice_out ($clog2(NUM_NA) bits), menor_endereco_out (ADR_WIDTH bits) and menor_custo_out (CUSTO_WIDTH bits).

Function
REQ-014 The block SHALL update the selected entries on the clock edge after escrever_in=1: endereco and custo are overwritten unconditionally and ativo is set to 1.
REQ-015 The block SHALL clear ativo of the selected entries on the clock edge after desativar_in=1, and SHALL retain their stored endereco and custo.
REQ-016 When escrever_in and desativar_in are both 1 in the same cycle, the block SHALL apply desativar only.
REQ-017 When habilitar_in is zero, the block SHALL treat the cycle as a no-op; when several bits are set, it SHALL apply the operation to every selected entry.
REQ-018 The block SHALL keep num_ativos_out equal to the popcount of na_ativo_out in the same cycle, with cheio_out=(count==NUM_NA) and vazio_out=(count==0).
REQ-019 The block SHALL implement a search FSM with states ST_IDLE, ST_VARRENDO and ST_FIM.
REQ-020 In ST_IDLE with buscar_in=1, the FSM SHALL clear the index counter and the best-candidate register and move to ST_VARRENDO; buscar_in in any other state SHALL be ignored.
REQ-021 In ST_VARRENDO the FSM SHALL visit one entry per cycle at indices 0..NUM_NA-1, and SHALL replace the candidate only if the entry is active and (no candidate exists yet, or custo is strictly less than the candidate's), so ties resolve to the lowest index.
REQ-022 After visiting index NUM_NA-1, the FSM SHALL enter ST_FIM; with no write, the result SHALL appear exactly NUM_NA+1 cycles after buscar_in is sampled.
REQ-023 Any accepted escrever_in or desativar_in during ST_VARRENDO SHALL restart the scan on the next cycle from index 0 with the candidate cleared.
REQ-024 In ST_FIM the block SHALL pulse menor_valido_out for one cycle, present the candidate on the menor_* outputs, and return to ST_IDLE.
REQ-025 If no entry is active, the block SHALL set menor_nenhum_out=1 for the ST_FIM cycle and drive menor_indice_out, menor_endereco_out and menor_custo_out to 0.
REQ-026 The menor_* data outputs SHALL hold their value until the next ST_FIM, and ocupado_out SHALL be 1 in ST_VARRENDO and ST_FIM.

Reset
REQ-027 On rst_n=0, the block SHALL asynchronously clear all entries to endereco=0, custo=0 and ativo=0, and set the FSM to ST_IDLE.
REQ-028 On rst_n=0, the block SHALL clear all menor_* outputs, ocupado_out and num_ativos_out to 0, and set vazio_out=1 and cheio_out=0.
REQ-029 A reset asserted mid-scan SHALL abort the scan with no menor_valido_out pulse.

Structure
REQ-030 A shared package SHALL hold the ST_* encodings, the default NUM_NA, ADR_WIDTH and CUSTO_WIDTH values, and the derived index and count widths, so the block and the active-node manager use the same values.
REQ-031 The block SHALL instantiate NUM_NA copies of one sub-module, registro_na, each holding a single entry's endereco, custo and ativo and its write/deactivate logic; the scan FSM and counter SHALL be top-level.

Verification
REQ-032 The bench SHALL write entries 2, 5 and 7 with costs 30, 10 and 10, then assert buscar_in, and SHALL check a menor_valido_out pulse 9 cycles later with indice=5, custo=10 and num_ativos_out=3.
REQ-033 The bench SHALL assert buscar_in with all entries inactive and SHALL check menor_valido_out=1, menor_nenhum_out=1 and all menor_* data outputs at 0.
REQ-034 The bench SHALL drive escrever_in and desativar_in together with habilitar_in=8'h04 while entry 2 is active, and SHALL check that entry 2 becomes inactive and its endereco is unchanged.
REQ-035 The bench SHALL write entry 0 with custo=1 in the 4th cycle of a scan, and SHALL check that the scan restarts and that the result is indice=0 and custo=1, arriving 4 cycles later than an uninterrupted scan.
REQ-036 The bench SHALL write all 8 entries and check cheio_out=1, then deactivate entry 3 and check cheio_out=0 and num_ativos_out=7.
REQ-037 The bench SHALL assert rst_n low during ST_VARRENDO and SHALL check no menor_valido_out pulse, all entries inactive and vazio_out=1.
